// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - IF/DM arbiter for the shared off-chip SRAM port
//
// Purpose: grants the single SRAM port to either the instruction-fetch (IF) or
// the data-memory (DM) requester. Each access is held for WAIT_CYCLES+1 cycles,
// and the winner then gets a one-cycle acknowledge together with its read data.
// All outputs are registered.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           IF request (level) and word address
//   if_rdata/if_ack          IF read data and completion pulse
//   dm_req/dm_we/dm_be       DM request (level), write flag, byte enables
//   dm_addr/dm_wdata         DM word address and write data
//   dm_rdata/dm_ack          DM read data and completion pulse
//   mem_cs/mem_we/mem_be     SRAM chip select, write strobe, byte enables
//   mem_addr/mem_wdata       SRAM word address and write data
//   mem_rdata                SRAM read data
//   busy                     arbiter not idle (CPU stall source)
//
// Build option: define MEM_ARB_FAIR_EN to let IF through after MAX_DM_BURST
// consecutive DM grants made while IF was waiting. Without it, DM has strict
// priority.

module shared_mem_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int WAIT_CYCLES  = 2,
  parameter int MAX_DM_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  // Both counters are 4 bits wide, so larger settings cannot be honoured.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || MAX_DM_BURST < 0 || MAX_DM_BURST > 15) begin : g_param_check
    $error("shared_mem_arbiter: WAIT_CYCLES and MAX_DM_BURST must be within 0..15");
  end

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant_dm_q, grant_dm_d;
  logic              busy_q, busy_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              dm_wins;

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] BURST_LIM = 4'(MAX_DM_BURST);
  logic [3:0] fair_q, fair_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_dm_d  = grant_dm_q;
    busy_d      = busy_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

`ifdef MEM_ARB_FAIR_EN
    fair_d  = fair_q;
    // Once DM has used up its burst while IF waits, IF takes the next slot.
    dm_wins = dm_req && !(if_req && (fair_q == BURST_LIM));
`else
    dm_wins = dm_req;
`endif

    case (state_q)
      S_IDLE: begin
        if (dm_wins) begin
          state_d     = S_ACCESS;
          cnt_d       = 4'd0;
          grant_dm_d  = 1'b1;
          busy_d      = 1'b1;
          mem_cs_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_be_d    = dm_we ? dm_be : 4'hF;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
`ifdef MEM_ARB_FAIR_EN
          fair_d      = if_req ? fair_q + 4'd1 : 4'd0;
`endif
        end else if (if_req) begin
          state_d     = S_ACCESS;
          cnt_d       = 4'd0;
          grant_dm_d  = 1'b0;
          busy_d      = 1'b1;
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'hF;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'h0;
`ifdef MEM_ARB_FAIR_EN
          fair_d      = 4'd0;
`endif
        end
      end

      S_ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          // Last access cycle: sample the SRAM and release the bus together,
          // so the data is already valid when the ack is seen.
          state_d  = S_DONE;
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          mem_be_d = 4'h0;
          if (grant_dm_q) begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        mem_be_d = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      grant_dm_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      fair_q      <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_dm_q  <= grant_dm_d;
      busy_q      <= busy_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
`ifdef MEM_ARB_FAIR_EN
      fair_q      <= fair_d;
`endif
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - directed self-checking bench for shared_mem_arbiter

module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [19:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [19:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_cs;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(
    .ADDR_W(20),
    .WAIT_CYCLES(2),
    .MAX_DM_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ack(if_ack),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_be(dm_be),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_ack(dm_ack),
    .mem_cs(mem_cs),
    .mem_we(mem_we),
    .mem_be(mem_be),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles after the arbitration edge (cycle 0) and checks that each
  // ack appears only in its expected cycle (0 = never). Requests drop on ack.
  task automatic run_acks(input string tag, input int n, input int exp_if, input int exp_dm);
    for (int c = 1; c <= n; c++) begin
      step();
      check($sformatf("%s_if_ack_c%0d", tag, c), {31'b0, if_ack}, {31'b0, c == exp_if});
      check($sformatf("%s_dm_ack_c%0d", tag, c), {31'b0, dm_ack}, {31'b0, c == exp_dm});
      if (if_ack) if_req = 1'b0;
      if (dm_ack) dm_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq[$];
    int exp_seq[6];

    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_be     = 4'h0;
    dm_addr   = '0;
    dm_wdata  = 32'h0;
    mem_rdata = 32'h0;
    step();
    step();
    check("rst_mem_cs", {31'b0, mem_cs}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    rst = 1'b0;
    step();

    // IF read: cs high cycles 1..3, ack cycle 4.
    if_req    = 1'b1;
    if_addr   = 20'h00010;
    mem_rdata = 32'h3C08ABCD;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("ifrd_cs_c%0d", c), {31'b0, mem_cs}, {31'b0, c <= 3});
      check($sformatf("ifrd_ack_c%0d", c), {31'b0, if_ack}, {31'b0, c == 4});
      check($sformatf("ifrd_busy_c%0d", c), {31'b0, busy}, {31'b0, c <= 4});
      if (c <= 3) begin
        check("ifrd_we", {31'b0, mem_we}, 32'd0);
        check("ifrd_be", {28'b0, mem_be}, 32'hF);
        check("ifrd_addr", {12'b0, mem_addr}, 32'h00010);
      end
      if (c == 4) begin
        check("ifrd_rdata", if_rdata, 32'h3C08ABCD);
        check("ifrd_done_be", {28'b0, mem_be}, 32'd0);
        if_req = 1'b0;
      end
    end

    // DM read to give dm_rdata a known non-zero value.
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_be     = 4'h3;
    dm_addr   = 20'h00100;
    mem_rdata = 32'h12345678;
    step();
    check("dmrd_be", {28'b0, mem_be}, 32'hF);
    run_acks("dmrd", 4, 0, 3);
    check("dmrd_rdata", dm_rdata, 32'h12345678);

    // DM byte write: we/be for three cycles, ack cycle 4, dm_rdata unchanged.
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_be     = 4'b0010;
    dm_addr   = 20'h00200;
    dm_wdata  = 32'h0000AB00;
    mem_rdata = 32'hDEADBEEF;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("dmwr_we_c%0d", c), {31'b0, mem_we}, {31'b0, c <= 3});
      check($sformatf("dmwr_be_c%0d", c), {28'b0, mem_be}, (c <= 3) ? 32'h2 : 32'h0);
      check($sformatf("dmwr_ack_c%0d", c), {31'b0, dm_ack}, {31'b0, c == 4});
      if (c <= 3) begin
        check("dmwr_addr", {12'b0, mem_addr}, 32'h00200);
        check("dmwr_wdata", mem_wdata, 32'h0000AB00);
      end
      if (c == 4) begin
        check("dmwr_rdata_kept", dm_rdata, 32'h12345678);
        dm_req = 1'b0;
      end
    end
    dm_we = 1'b0;

    // Simultaneous requests: DM first (ack 4), IF next (ack 9).
    if_req    = 1'b1;
    if_addr   = 20'h00044;
    dm_req    = 1'b1;
    dm_addr   = 20'h00300;
    mem_rdata = 32'hCAFEF00D;
    run_acks("sim", 10, 9, 4);
    check("sim_if_rdata", if_rdata, 32'hCAFEF00D);
    check("sim_dm_rdata", dm_rdata, 32'hCAFEF00D);

    // Back-to-back DM reads, address changes after the first ack.
    dm_req    = 1'b1;
    dm_addr   = 20'h00400;
    mem_rdata = 32'h0BADC0DE;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("b2b_busy_c%0d", c), {31'b0, busy}, {31'b0, !(c == 5 || c == 10)});
      check($sformatf("b2b_ack_c%0d", c), {31'b0, dm_ack}, {31'b0, c == 4 || c == 9});
      if (c <= 3) check("b2b_addr_a", {12'b0, mem_addr}, 32'h00400);
      if (c >= 6 && c <= 8) check("b2b_addr_b", {12'b0, mem_addr}, 32'h00408);
      if (c == 4) dm_addr = 20'h00408;
      if (c == 9) dm_req = 1'b0;
    end

    // Reset in the second access cycle aborts; the held request then completes.
    if_req    = 1'b1;
    if_addr   = 20'h00020;
    mem_rdata = 32'h11112222;
    step();
    step();
    rst = 1'b1;
    step();
    check("mrst_cs", {31'b0, mem_cs}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
    check("mrst_if_rdata", if_rdata, 32'd0);
    check("mrst_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b0;
    run_acks("rereq", 5, 4, 0);
    check("rereq_rdata", if_rdata, 32'h11112222);

    // Both requests held continuously: record the ack order.
    if_req    = 1'b1;
    dm_req    = 1'b1;
    if_addr   = 20'h00050;
    dm_addr   = 20'h00060;
    mem_rdata = 32'h55AA55AA;
    for (int c = 1; c <= 30; c++) begin
      step();
      check("fair_ack_excl", {31'b0, if_ack & dm_ack}, 32'd0);
      if (dm_ack) seq.push_back(2);
      if (if_ack) seq.push_back(1);
    end
`ifdef MEM_ARB_FAIR_EN
    exp_seq = '{2, 2, 2, 2, 1, 2};
`else
    exp_seq = '{2, 2, 2, 2, 2, 2};
`endif
    check("fair_ack_count", seq.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < seq.size()) check($sformatf("fair_ack_%0d", k), seq[k], exp_seq[k]);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    for (int c = 0; c < 8; c++) step();
    check("end_idle_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
